// File: rtl/bpm_meter.sv
// bpm_meter
// Measures the interval between accepted rising edges of the heartbeat
// comparator output in 1 ms ticks and converts it to beats per minute
// (60000 / interval, truncated) with a 16-step restoring divider.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   tick_1ms   one-cycle enable strobe, once per millisecond
//   pulse      heartbeat level, synchronous to clk
//   bpm        last computed rate; 0 when no valid rate
//   bpm_valid  one-cycle strobe when bpm takes a new measurement
//   timeout    high while no accepted edge has arrived for MAX_INTERVAL ticks
module bpm_meter #(
    parameter logic [11:0] MIN_INTERVAL = 12'd300,
    parameter logic [11:0] MAX_INTERVAL = 12'd2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       pulse,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DIV   = 2'd2
    } state_t;

    localparam logic [15:0] DIVIDEND = 16'd60000;

    state_t      r_state;
    logic        r_pulse_d;
    logic [11:0] r_cnt;
    logic [11:0] r_divisor;
    logic [11:0] r_rem;
    logic [15:0] r_quo;     // dividend shifts out the top, quotient bits shift in the bottom
    logic [4:0]  r_step;

    logic        w_rise;
    logic        w_accept;
    logic [11:0] w_cnt_inc;
    logic [11:0] w_cnt_tick;
    logic [12:0] w_shift;
    logic        w_fits;
    logic [11:0] w_sub;
    logic [11:0] w_rem_next;

    assign w_rise     = pulse & ~r_pulse_d;
    assign w_accept   = (r_state == S_COUNT) && w_rise && (r_cnt >= MIN_INTERVAL);
    assign w_cnt_inc  = (r_cnt >= MAX_INTERVAL) ? MAX_INTERVAL : r_cnt + 12'd1;
    assign w_cnt_tick = tick_1ms ? w_cnt_inc : r_cnt;

    // One restoring-division step. The partial remainder is always below the
    // 12-bit divisor, so the difference fits in 12 bits whenever it is taken.
    assign w_shift    = {r_rem, r_quo[15]};
    assign w_fits     = w_shift >= {1'b0, r_divisor};
    assign w_sub      = w_shift[11:0] - r_divisor;
    assign w_rem_next = w_fits ? w_sub : w_shift[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pulse_d <= 1'b0;
            r_cnt     <= 12'd0;
            r_divisor <= 12'd0;
            r_rem     <= 12'd0;
            r_quo     <= 16'd0;
            r_step    <= 5'd0;
            bpm       <= 8'd0;
            bpm_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            r_pulse_d <= pulse;
            bpm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 12'd0;
                    if (w_rise) begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        // Edge wins over a coincident tick: the tick is dropped.
                        r_cnt     <= 12'd0;
                        r_divisor <= r_cnt;
                        r_rem     <= 12'd0;
                        r_quo     <= DIVIDEND;
                        r_step    <= 5'd0;
                        r_state   <= S_DIV;
                    end else if (w_cnt_tick == MAX_INTERVAL) begin
                        timeout <= 1'b1;
                        bpm     <= 8'd0;
                        r_cnt   <= 12'd0;
                        r_state <= S_IDLE;
                    end else begin
                        // Refractory rises fall through here and are ignored.
                        r_cnt <= w_cnt_tick;
                    end
                end
                S_DIV: begin
                    // The next interval is already being timed; rises are
                    // ignored because the counter is far below MIN_INTERVAL.
                    r_cnt <= w_cnt_tick;
                    if (r_step == 5'd16) begin
                        bpm       <= r_quo[7:0];
                        bpm_valid <= 1'b1;
                        timeout   <= 1'b0;
                        r_state   <= S_COUNT;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quo  <= {r_quo[14:0], w_fits};
                        r_step <= r_step + 5'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpm_meter.sv
// Self-checking bench for bpm_meter. A small behavioural model tracks the
// reference edge, ticks elapsed since it, expected rate and timeout level.
module tb_bpm_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1ms = 1'b0;
    logic       pulse = 1'b0;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       timeout;

    int nvec = 0;
    int nerr = 0;

    // behavioural model state
    bit m_ref   = 1'b0;
    int m_ticks = 0;
    int m_bpm   = 0;
    bit m_to    = 1'b0;

    bpm_meter dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .pulse    (pulse),
        .bpm      (bpm),
        .bpm_valid(bpm_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input logic p, input logic t);
        pulse    = p;
        tick_1ms = t;
        @(posedge clk);
        #1;
    endtask

    // Issue n ticks with random idle gaps, updating the model per tick.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            if (m_ref) begin
                m_ticks++;
                if (m_ticks >= 2000) begin
                    m_ref = 1'b0;
                    m_to  = 1'b1;
                    m_bpm = 0;
                end
            end
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
        end
    endtask

    // Model reaction to a rising edge; q = -1 when no measurement results.
    task automatic model_edge(input bit t, output int q);
        q = -1;
        if (!m_ref) begin
            m_ref   = 1'b1;
            m_ticks = 0;
        end else if (m_ticks >= 300) begin
            q       = 60000 / m_ticks;
            m_bpm   = q;
            m_to    = 1'b0;
            m_ticks = 0;
        end else if (t) begin
            m_ticks++;
        end
    endtask

    // Drive one rising edge (cycle 0) then watch 19 more cycles without ticks.
    task automatic send_edge(input bit t, output int vc, output int vn,
                             output int vb, output int vt);
        vc = -1; vn = 0; vb = -1; vt = -1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) step(1'b1, t);
            else        step(1'b0, 1'b0);
            if (bpm_valid === 1'b1) begin
                vn++;
                if (vc < 0) begin
                    vc = k;
                    vb = int'(bpm);
                    vt = int'(timeout);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        nvec++;
        if (bpm !== 8'd0 || bpm_valid !== 1'b0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL reset: bpm=%0d valid=%b timeout=%b, expected 0/0/0", bpm, bpm_valid, timeout);
        end
        rst = 1'b0;
        m_ref = 1'b0; m_ticks = 0; m_bpm = 0; m_to = 1'b0;
    endtask

    task automatic test_rates();
        int q, c, n, b, to;
        int iv[4];
        int ex[4];
        iv = '{1000, 1000, 857, 300};
        ex = '{60, 60, 70, 200};
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 0) begin
            nerr++;
            $display("FAIL first_edge: %0d valid pulses, expected 0", n);
        end
        for (int i = 0; i < 4; i++) begin
            wait_ticks(iv[i]);
            model_edge(1'b0, q);
            send_edge(1'b0, c, n, b, to);
            nvec++;
            if (n !== 1 || c !== 17 || b !== ex[i]) begin
                nerr++;
                $display("FAIL rate_%0d: %0d pulses at cycle %0d bpm %0d, expected 1 at 17 bpm %0d",
                         iv[i], n, c, b, ex[i]);
            end
        end
    endtask

    task automatic test_refractory();
        int q, c, n, b, to;
        wait_ticks(1000);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        wait_ticks(150);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 0 || bpm !== 8'd60) begin
            nerr++;
            $display("FAIL refractory_reject: %0d pulses bpm %0d, expected 0 pulses bpm 60", n, bpm);
        end
        wait_ticks(650);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 1 || c !== 17 || b !== 75) begin
            nerr++;
            $display("FAIL refractory_next: %0d pulses at %0d bpm %0d, expected 1 at 17 bpm 75", n, c, b);
        end
    endtask

    task automatic test_timeout();
        int q, c, n, b, to;
        wait_ticks(1000);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 1 || b !== 60) begin
            nerr++;
            $display("FAIL timeout_pre: %0d pulses bpm %0d, expected 1 bpm 60", n, b);
        end
        wait_ticks(1999);
        nvec++;
        if (timeout !== 1'b0 || bpm !== 8'd60) begin
            nerr++;
            $display("FAIL timeout_1999: timeout=%b bpm=%0d, expected 0 bpm 60", timeout, bpm);
        end
        wait_ticks(1);
        nvec++;
        if (timeout !== 1'b1 || bpm !== 8'd0) begin
            nerr++;
            $display("FAIL timeout_2000: timeout=%b bpm=%0d, expected 1 bpm 0", timeout, bpm);
        end
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 0 || timeout !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_first_edge: %0d pulses timeout=%b, expected 0 pulses timeout 1", n, timeout);
        end
        wait_ticks(600);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 1 || c !== 17 || b !== 100 || to !== 0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_recover: %0d pulses at %0d bpm %0d timeout %0d, expected 1 at 17 bpm 100 timeout 0",
                     n, c, b, to);
        end
    endtask

    task automatic test_tick_coincident();
        int q, c, n, b, to;
        wait_ticks(1000);
        model_edge(1'b1, q);
        send_edge(1'b1, c, n, b, to);
        nvec++;
        if (n !== 1 || b !== 60) begin
            nerr++;
            $display("FAIL coincident_edge: %0d pulses bpm %0d, expected 1 bpm 60", n, b);
        end
        wait_ticks(1000);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 1 || c !== 17 || b !== 60) begin
            nerr++;
            $display("FAIL coincident_next: %0d pulses at %0d bpm %0d, expected 1 at 17 bpm 60", n, c, b);
        end
    endtask

    task automatic test_reset_mid_div();
        int q, c, n, b, to;
        int seen;
        wait_ticks(500);
        step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        nvec++;
        if (bpm !== 8'd0 || bpm_valid !== 1'b0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL reset_async: bpm=%0d valid=%b timeout=%b, expected 0/0/0", bpm, bpm_valid, timeout);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        m_ref = 1'b0; m_ticks = 0; m_bpm = 0; m_to = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0);
            if (bpm_valid === 1'b1) seen++;
        end
        nvec++;
        if (seen !== 0 || bpm !== 8'd0) begin
            nerr++;
            $display("FAIL reset_abandon: %0d pulses bpm %0d, expected 0 pulses bpm 0", seen, bpm);
        end
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        wait_ticks(500);
        model_edge(1'b0, q);
        send_edge(1'b0, c, n, b, to);
        nvec++;
        if (n !== 1 || c !== 17 || b !== 120) begin
            nerr++;
            $display("FAIL reset_recover: %0d pulses at %0d bpm %0d, expected 1 at 17 bpm 120", n, c, b);
        end
    endtask

    task automatic test_random();
        int q, c, n, b, to, iv;
        bit t;
        for (int i = 0; i < 8; i++) begin
            iv = $urandom_range(100, 2100);
            t  = 1'($urandom_range(0, 1));
            wait_ticks(iv);
            model_edge(t, q);
            send_edge(t, c, n, b, to);
            nvec++;
            if (q < 0) begin
                if (n !== 0) begin
                    nerr++;
                    $display("FAIL random_%0d: %0d pulses, expected none", i, n);
                end
            end else if (n !== 1 || c !== 17 || b !== q) begin
                nerr++;
                $display("FAIL random_%0d: %0d pulses at %0d bpm %0d, expected 1 at 17 bpm %0d", i, n, c, b, q);
            end
            nvec++;
            if (int'(bpm) !== m_bpm || timeout !== m_to) begin
                nerr++;
                $display("FAIL random_state_%0d: bpm=%0d timeout=%b, expected bpm %0d timeout %0d",
                         i, bpm, timeout, m_bpm, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rates();
        test_refractory();
        test_timeout();
        test_tick_coincident();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bpm_meter.md
Name: bpm_meter

Overview:
- Consumes the 1-bit hysteresis-comparator heartbeat output (`pulse`, same clock domain) and measures the interval between successive rising edges in 1 ms ticks.
- Converts each valid interval to beats per minute: 60000 / interval_ms, truncated.
- Sits between the pulse comparator and the display/reporting logic.
- Rejects edges arriving too soon (refractory) and reports loss of signal (timeout).

Parameters:
MIN_INTERVAL, 12'd300, minimum accepted edge-to-edge interval in ticks (caps at 200 BPM)
MAX_INTERVAL, 12'd2000, interval in ticks at which timeout is declared (floor of 30 BPM)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tick_1ms  input  1  one-cycle enable strobe, once per millisecond
pulse  input  1  heartbeat level from the pulse comparator, synchronous to clk
bpm  output  8  last computed rate in BPM; 0 when no valid rate
bpm_valid  output  1  one-cycle strobe when bpm updates with a new measurement
timeout  output  1  level; 1 while no accepted edge has arrived for MAX_INTERVAL ticks

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: bpm=0, bpm_valid=0, timeout=0, state=IDLE, interval counter=0, pulse_d=0, divider regs=0.
- Edge detect: pulse_d registers pulse. rise = pulse & ~pulse_d.
- Interval counter (12 bit):
  - Cleared on an accepted edge.
  - Otherwise +1 on tick_1ms, saturating at MAX_INTERVAL.
  - If an accepted edge and a tick occur in the same cycle, the edge wins: counter = 0 and that tick is dropped.
- States:
  - IDLE: no reference edge. Counter held at 0.
    - rise -> COUNT, counter = 0. No measurement.
  - COUNT: counter running.
    - rise with counter < MIN_INTERVAL -> ignored. Counter not cleared, no output change.
    - rise with counter >= MIN_INTERVAL -> latch divisor = counter, clear counter, -> DIV.
    - counter reaches MAX_INTERVAL with no accepted edge -> timeout=1, bpm=0, -> IDLE.
  - DIV: 16-step restoring division, dividend 16'd60000, divisor 12-bit zero-extended, one quotient bit per clk.
    - Counter keeps running during DIV.
    - rise during DIV is ignored (counter < MIN_INTERVAL is guaranteed for any MIN_INTERVAL >= 17 at 1 tick/cycle or slower).
    - On completion: bpm = quotient[7:0], bpm_valid = 1 for exactly one cycle, timeout = 0, -> COUNT.
    - Latency: accepted edge to bpm_valid = 17 clk cycles. Edge cycle latches; 16 divide cycles; result registered on the 17th.
- Quotient width: for MIN_INTERVAL >= 236 the quotient is <= 254, so the upper 8 bits are always zero. MIN_INTERVAL < 236 is unsupported.
- timeout:
  - Set only on the COUNT->IDLE timeout transition.
  - Cleared only by the next bpm_valid.
  - The first edge after a timeout does not clear it; two accepted edges are required.
- bpm holds its value between updates.
- rst asserted mid-DIV: abandon the division, all outputs to reset values immediately (asynchronous), no bpm_valid.
- pulse held high continuously produces no further rises and therefore leads to timeout.

Test Plan:
- Reset, then rising edges on pulse spaced exactly 1000 ticks apart -> first edge gives no output; second gives bpm_valid one cycle at edge+17 clk with bpm=60; third repeats 60.
- Edges spaced 857 ticks -> bpm=70 (60000/857=70.01, truncated). Edges spaced 300 ticks -> bpm=200 (boundary accepted).
- Valid edge, extra rise at 150 ticks, next rise at 800 ticks after the first -> extra rise ignored, bpm=75, exactly one bpm_valid.
- Two edges 1000 apart (bpm=60), then no edges for 2000 ticks -> timeout=1 and bpm=0 at tick 2000; next edge gives no output; edge 600 later -> bpm=100, timeout=0 in the same cycle as bpm_valid.
- tick_1ms coincident with an accepted rise -> counter reads 0 the next cycle; the following interval is measured from that edge (1000-tick spacing still gives 60).
- Assert rst 5 clk into DIV -> bpm=0, bpm_valid never pulses, timeout=0, state IDLE; after release, two edges 500 apart -> bpm=120.
